// File: rtl/mem_write_checker_if.sv
// Data-memory write port of the core, as observed by the store checker.
// The core (or a bench) drives it as master; the checker listens as slave.
interface mem_write_checker_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic              memwrite;
    logic [ADDR_W-1:0] dataadr;
    logic [DATA_W-1:0] writedata;

    modport master (
        output memwrite,
        output dataadr,
        output writedata
    );

    modport slave (
        input memwrite,
        input dataadr,
        input writedata
    );
endinterface

// File: rtl/mem_write_checker.sv
// Store monitor for the core's data-memory port: PASS on the completion store,
// FAIL on stray, misaligned or wrong-valued stores, or on timeout; restartable via clear.
module mem_write_checker #(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] DONE_ADDR  = ADDR_W'(84),
    parameter logic [DATA_W-1:0] DONE_DATA  = DATA_W'(32'hFFFF7F02),
    parameter logic [ADDR_W-1:0] ALLOW_LO   = ADDR_W'(80),
    parameter logic [ADDR_W-1:0] ALLOW_HI   = ADDR_W'(80),
    parameter bit                ADDR_ALIGN = 1'b1,
    parameter int unsigned       TIMEOUT    = 1000,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    mem_write_checker_if.slave  bus,
    output logic [1:0]          status,
    output logic                pass,
    output logic                fail,
    output logic [2:0]          fail_code,
    output logic [ADDR_W-1:0]   fail_addr,
    output logic [DATA_W-1:0]   fail_data,
    output logic [CNT_W-1:0]    write_count,
    output logic [CNT_W-1:0]    cycle_count
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b01,
        ST_PASS = 2'b10,
        ST_FAIL = 2'b11
    } state_t;

    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_WINDOW   = 3'd1;
    localparam logic [2:0] CODE_ALIGN    = 3'd2;
    localparam logic [2:0] CODE_BAD_DONE = 3'd3;
    localparam logic [2:0] CODE_TIMEOUT  = 3'd4;

    localparam bit               TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] TO_LAST    = TIMEOUT_EN ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

    state_t state;

    logic below_lo_c;
    logic above_hi_c;
    logic at_done_c;
    logic done_ok_c;
    logic misalign_c;
    logic timeout_c;

    // Window bounds at the extremes of the address range can never be violated.
    if (ALLOW_LO == '0) begin : g_no_lo
        assign below_lo_c = 1'b0;
    end else begin : g_lo
        assign below_lo_c = (bus.dataadr < ALLOW_LO);
    end

    if (ALLOW_HI == ADDR_MAX) begin : g_no_hi
        assign above_hi_c = 1'b0;
    end else begin : g_hi
        assign above_hi_c = (bus.dataadr > ALLOW_HI);
    end

    always_comb begin
        at_done_c  = (bus.dataadr == DONE_ADDR);
        done_ok_c  = at_done_c && (bus.writedata == DONE_DATA);
        misalign_c = ADDR_ALIGN && (bus.dataadr[1:0] != 2'b00);
        timeout_c  = TIMEOUT_EN && (cycle_count == TO_LAST);
    end

    assign status = state;

    // Verdict FSM with counters and failure capture; PASS/FAIL hold until clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_RUN;
            pass        <= 1'b0;
            fail        <= 1'b0;
            fail_code   <= CODE_NONE;
            fail_addr   <= '0;
            fail_data   <= '0;
            write_count <= '0;
            cycle_count <= '0;
        end else if (clear) begin
            state       <= ST_RUN;
            pass        <= 1'b0;
            fail        <= 1'b0;
            fail_code   <= CODE_NONE;
            fail_addr   <= '0;
            fail_data   <= '0;
            write_count <= '0;
            cycle_count <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (cycle_count != CNT_MAX) begin
                        cycle_count <= cycle_count + CNT_W'(1);
                    end
                    if (bus.memwrite && (write_count != CNT_MAX)) begin
                        write_count <= write_count + CNT_W'(1);
                    end

                    // Store checks outrank the timeout on the same edge.
                    if (bus.memwrite && done_ok_c) begin
                        state <= ST_PASS;
                        pass  <= 1'b1;
                    end else if (bus.memwrite && misalign_c) begin
                        state     <= ST_FAIL;
                        fail      <= 1'b1;
                        fail_code <= CODE_ALIGN;
                        fail_addr <= bus.dataadr;
                        fail_data <= bus.writedata;
                    end else if (bus.memwrite && at_done_c) begin
                        state     <= ST_FAIL;
                        fail      <= 1'b1;
                        fail_code <= CODE_BAD_DONE;
                        fail_addr <= bus.dataadr;
                        fail_data <= bus.writedata;
                    end else if (bus.memwrite && (below_lo_c || above_hi_c)) begin
                        state     <= ST_FAIL;
                        fail      <= 1'b1;
                        fail_code <= CODE_WINDOW;
                        fail_addr <= bus.dataadr;
                        fail_data <= bus.writedata;
                    end else if (timeout_c) begin
                        state     <= ST_FAIL;
                        fail      <= 1'b1;
                        fail_code <= CODE_TIMEOUT;
                        fail_addr <= '0;
                        fail_data <= '0;
                    end
                end
                ST_PASS, ST_FAIL: begin
                    state <= state;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: three differently parameterised instances, a rule-level
// reference model compared every cycle, and directed stores with literal expectations.
module tb_mem_write_checker;

    localparam logic [31:0] DONE = 32'hFFFF7F02;

    typedef struct {
        int          st;     // 0 run, 1 pass, 2 fail
        int          code;
        logic [31:0] addr;
        logic [31:0] data;
        int          wc;
        int          cc;
    } mdl_t;

    logic clk;
    logic reset;
    logic clr_a, clr_b, clr_c;

    int n_checks = 0;
    int n_errors = 0;

    mem_write_checker_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
    mem_write_checker_if #(.ADDR_W(32), .DATA_W(32)) ifb ();
    mem_write_checker_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

    logic [1:0]  st_a, st_b, st_c;
    logic        pass_a, pass_b, pass_c;
    logic        fail_a, fail_b, fail_c;
    logic [2:0]  code_a, code_b, code_c;
    logic [31:0] faddr_a, faddr_b, faddr_c;
    logic [31:0] fdata_a, fdata_b, fdata_c;
    logic [15:0] wc_a, wc_b, wc_c;
    logic [15:0] cc_a, cc_b, cc_c;

    mem_write_checker u_a (
        .clk(clk), .reset(reset), .clear(clr_a), .bus(ifa),
        .status(st_a), .pass(pass_a), .fail(fail_a), .fail_code(code_a),
        .fail_addr(faddr_a), .fail_data(fdata_a), .write_count(wc_a), .cycle_count(cc_a)
    );

    mem_write_checker #(.TIMEOUT(10)) u_b (
        .clk(clk), .reset(reset), .clear(clr_b), .bus(ifb),
        .status(st_b), .pass(pass_b), .fail(fail_b), .fail_code(code_b),
        .fail_addr(faddr_b), .fail_data(fdata_b), .write_count(wc_b), .cycle_count(cc_b)
    );

    mem_write_checker #(.ADDR_ALIGN(1'b0), .ALLOW_LO(32'd0), .ALLOW_HI(32'd255), .TIMEOUT(0)) u_c (
        .clk(clk), .reset(reset), .clear(clr_c), .bus(ifc),
        .status(st_c), .pass(pass_c), .fail(fail_c), .fail_code(code_c),
        .fail_addr(faddr_c), .fail_data(fdata_c), .write_count(wc_c), .cycle_count(cc_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mdl_t reset_m();
        mdl_t m;
        m.st = 0; m.code = 0; m.addr = '0; m.data = '0; m.wc = 0; m.cc = 0;
        return m;
    endfunction

    // One clock edge of the checker's rules, in plain arithmetic.
    function automatic mdl_t step(mdl_t m, logic clr, logic mw, logic [31:0] a, logic [31:0] d,
                                  int tmo, bit align, logic [31:0] lo, logic [31:0] hi);
        mdl_t n;
        if (clr) return reset_m();
        if (m.st != 0) return m;
        n = m;
        n.cc = (m.cc < 65535) ? m.cc + 1 : m.cc;
        if (mw) n.wc = (m.wc < 65535) ? m.wc + 1 : m.wc;
        if (mw && a == 32'd84 && d == DONE) begin
            n.st = 1;
        end else if (mw && ((align && (a % 4) != 0) || a == 32'd84 || a < lo || a > hi)) begin
            n.st = 2; n.addr = a; n.data = d;
            if (align && (a % 4) != 0) n.code = 2;
            else if (a == 32'd84)      n.code = 3;
            else                       n.code = 1;
        end else if (tmo != 0 && m.cc == tmo - 1) begin
            n.st = 2; n.code = 4;
        end
        return n;
    endfunction

    function automatic logic [102:0] exp_of(mdl_t m);
        logic [1:0] s;
        s = (m.st == 0) ? 2'b01 : (m.st == 1) ? 2'b10 : 2'b11;
        return {s, 1'(m.st == 1), 1'(m.st == 2), 3'(m.code), m.addr, m.data, 16'(m.wc), 16'(m.cc)};
    endfunction

    mdl_t m_a, m_b, m_c;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_a <= reset_m();
            m_b <= reset_m();
            m_c <= reset_m();
        end else begin
            m_a <= step(m_a, clr_a, ifa.memwrite, ifa.dataadr, ifa.writedata, 1000, 1'b1, 32'd80, 32'd80);
            m_b <= step(m_b, clr_b, ifb.memwrite, ifb.dataadr, ifb.writedata, 10, 1'b1, 32'd80, 32'd80);
            m_c <= step(m_c, clr_c, ifc.memwrite, ifc.dataadr, ifc.writedata, 0, 1'b0, 32'd0, 32'd255);
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_vec(string name, logic [102:0] act, logic [102:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle out of reset, each instance must match the model.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk_vec("cycle_a", {st_a, pass_a, fail_a, code_a, faddr_a, fdata_a, wc_a, cc_a}, exp_of(m_a));
            chk_vec("cycle_b", {st_b, pass_b, fail_b, code_b, faddr_b, fdata_b, wc_b, cc_b}, exp_of(m_b));
            chk_vec("cycle_c", {st_c, pass_c, fail_c, code_c, faddr_c, fdata_c, wc_c, cc_c}, exp_of(m_c));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_clear(int which);
        if (which == 0) clr_a = 1'b1;
        if (which == 1) clr_b = 1'b1;
        if (which == 2) clr_c = 1'b1;
        tick();
        clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
        ifa.memwrite = 1'b0; ifa.dataadr = '0; ifa.writedata = '0;
        ifb.memwrite = 1'b0; ifb.dataadr = '0; ifb.writedata = '0;
        ifc.memwrite = 1'b0; ifc.dataadr = '0; ifc.writedata = '0;

        #21;
        chk_vec("reset_state", {st_a, pass_a, fail_a, code_a, faddr_a, fdata_a, wc_a, cc_a}, {2'b01, 101'b0});
        #1 reset = 1'b1;
        tick();

        // Window store then the completion store.
        ifa.memwrite = 1'b1; ifa.dataadr = 32'd80; ifa.writedata = 32'd7;
        tick();
        ifa.dataadr = 32'd84; ifa.writedata = DONE;
        tick();
        ifa.memwrite = 1'b0;
        chk("pass_status", 32'(st_a), 32'(2'b10));
        chk("pass_flag", 32'(pass_a), 32'd1);
        chk("pass_wcount", 32'(wc_a), 32'd2);
        chk("pass_code", 32'(code_a), 32'd0);
        chk("model_wcount", 32'(m_a.wc), 32'd2);
        repeat (3) tick();
        chk("pass_held", 32'(st_a), 32'(2'b10));

        // Out-of-window store above the window, then an ignored completion store.
        pulse_clear(0);
        chk("clear_status", 32'(st_a), 32'(2'b01));
        chk("clear_counts", 32'({wc_a, cc_a}), 32'd0);
        ifa.memwrite = 1'b1; ifa.dataadr = 32'd88; ifa.writedata = 32'd5;
        tick();
        chk("win_fail", 32'(fail_a), 32'd1);
        chk("win_code", 32'(code_a), 32'd1);
        chk("win_addr", faddr_a, 32'd88);
        chk("win_data", fdata_a, 32'd5);
        ifa.dataadr = 32'd84; ifa.writedata = DONE;
        tick();
        ifa.memwrite = 1'b0;
        tick();
        chk("fail_terminal", 32'({st_a, code_a}), 32'({2'b11, 3'd1}));

        // Below the window, still aligned.
        pulse_clear(0);
        ifa.memwrite = 1'b1; ifa.dataadr = 32'd76; ifa.writedata = 32'd3;
        tick();
        ifa.memwrite = 1'b0;
        chk("low_code", 32'(code_a), 32'd1);

        // Misaligned store, then wrong completion data.
        pulse_clear(0);
        ifa.memwrite = 1'b1; ifa.dataadr = 32'd82; ifa.writedata = 32'd0;
        tick();
        ifa.memwrite = 1'b0;
        chk("align_code", 32'(code_a), 32'd2);
        chk("align_addr", faddr_a, 32'd82);
        pulse_clear(0);
        ifa.memwrite = 1'b1; ifa.dataadr = 32'd84; ifa.writedata = 32'd1;
        tick();
        ifa.memwrite = 1'b0;
        chk("baddone_code", 32'(code_a), 32'd3);
        chk("baddone_data", fdata_a, 32'd1);

        // Clear from FAIL, a little activity, then an asynchronous reset pulse between edges.
        pulse_clear(0);
        chk("clear_from_fail", 32'({st_a, code_a}), 32'({2'b01, 3'd0}));
        ifa.memwrite = 1'b1; ifa.dataadr = 32'd80; ifa.writedata = 32'd1;
        tick();
        ifa.memwrite = 1'b0;
        tick();
        tick();
        chk("run_counts", 32'({wc_a, cc_a}), {16'd1, 16'd3});
        #1 reset = 1'b0;
        #1;
        chk("async_counts", 32'({wc_a, cc_a}), 32'd0);
        chk("async_status", 32'({st_a, pass_a, fail_a, code_a}), 32'({2'b01, 5'd0}));
        #1 reset = 1'b1;
        tick();

        // Timeout with nothing stored.
        pulse_clear(1);
        repeat (9) tick();
        chk("to_before", 32'({st_b, cc_b}), {14'd0, 2'b01, 16'd9});
        tick();
        chk("to_code", 32'(code_b), 32'd4);
        chk("to_fail", 32'(fail_b), 32'd1);
        chk("to_count", 32'(cc_b), 32'd10);
        chk("to_addr", faddr_b, 32'd0);

        // Completion store landing on the timeout edge wins.
        pulse_clear(1);
        repeat (9) tick();
        ifb.memwrite = 1'b1; ifb.dataadr = 32'd84; ifb.writedata = DONE;
        tick();
        ifb.memwrite = 1'b0;
        chk("to_edge_pass", 32'({st_b, pass_b}), 32'({2'b10, 1'b1}));
        chk("to_edge_count", 32'(cc_b), 32'd10);

        // Relaxed instance: odd address accepted, counter saturates with no timeout.
        pulse_clear(2);
        ifc.memwrite = 1'b1; ifc.dataadr = 32'd3; ifc.writedata = 32'd9;
        tick();
        ifc.memwrite = 1'b0;
        chk("relaxed_accept", 32'({st_c, wc_c}), {14'd0, 2'b01, 16'd1});
        repeat (70000) tick();
        chk("sat_count", 32'(cc_c), 32'h0000FFFF);
        chk("sat_status", 32'(st_c), 32'(2'b01));
        chk("model_sat", 32'(m_c.cc), 32'd65535);
        ifc.memwrite = 1'b1; ifc.dataadr = 32'd256; ifc.writedata = 32'd4;
        tick();
        ifc.memwrite = 1'b0;
        chk("relaxed_hi_code", 32'(code_c), 32'd1);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
